psx_input_decoder: RTL and testbench
====================================

Name: psx_input_decoder

Overview:
- Consumes `button_state[15:0]` and `stick_state[31:0]` from the PSX console poller and produces clean game-action signals for the T-Rex game core.
- The poller updates its byte registers bit-by-bit during a poll frame, so raw inputs are torn mid-frame. This block accepts a snapshot only after the inputs have been quiet for a programmable window.
- From the accepted snapshot it derives jump, duck and start actions: edge detection, jump auto-repeat, and a left-stick deadzone.

Parameters:
- STABLE_CYCLES, 1024: consecutive unchanged cycles required before the inputs are accepted as a snapshot. Must be >= 2.
- DEADZONE, 8'h30: left-stick Y deadzone half-width around centre 8'h80. Legal range 0..8'h7F.
- REPEAT_DELAY, 600000: cycles jump must be held after the first pulse before auto-repeat starts.
- REPEAT_PERIOD, 200000: cycles between auto-repeat jump pulses.

Ports:
- clk  in  1  system clock; same clock as the console poller.
- rst  in  1  synchronous reset, active-high.
- button_state  in  16  raw buttons, active-low. Bit map: [15] SELECT, [12] START, [11] UP, [9] DOWN, [2] CIRCLE, [1] CROSS.
- stick_state  in  32  {rx, ry, lx, ly}. ly = [7:0]; 8'h00 = full up, 8'hFF = full down.
- snap_valid  out  1  one-cycle pulse when an accepted snapshot differs from the previous one.
- snap_buttons  out  16  accepted buttons, inverted to active-high.
- jump_pulse  out  1  one-cycle jump request.
- jump_held  out  1  level; jump condition true in the current snapshot.
- duck  out  1  level; duck condition true and jump not true.
- start_pulse  out  1  one-cycle pulse on START rising edge.

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - Internal snapshot = idle {16'hFFFF, 32'h80808080}.
  - Previous-sample register = idle value.
  - Stability counter = 0.
  - Jump FSM = J_IDLE.
- Stability filter:
  - Each cycle, compare the raw 48-bit input with the previous-cycle sample.
  - If they differ, clear the counter to 0. Otherwise increment, saturating at STABLE_CYCLES.
  - When the counter first reaches STABLE_CYCLES-1 → STABLE_CYCLES, copy the sample into the snapshot. This happens exactly once per quiet period.
  - If the new snapshot differs from the old one, pulse snap_valid in the cycle after the copy.
  - Latency: a change at cycle t, held steady, is accepted at cycle t+STABLE_CYCLES. Derived outputs update one cycle later.
- Action derivation (from the snapshot only, active-high):
  - up = UP | CROSS | (ly < 8'h80 - DEADZONE).
  - dn = DOWN | CIRCLE | (ly > 8'h80 + DEADZONE).
  - Compute both thresholds in 9 bits; no wrap.
  - jump_held = up.
  - duck = dn & ~up. Jump wins on conflict.
- start_pulse: on a 0→1 transition of snapshot START; one cycle.
- Jump FSM:
  - J_IDLE: on up, pulse jump_pulse, load timer = REPEAT_DELAY, go to J_HOLD.
  - J_HOLD: if ~up go to J_IDLE. Else when timer reaches 0, pulse jump_pulse, load timer = REPEAT_PERIOD, go to J_REPEAT.
  - J_REPEAT: if ~up go to J_IDLE. Else on timer 0, pulse jump_pulse and reload REPEAT_PERIOD.
  - Release and re-press inside one snapshot cannot occur; each snapshot is a single value.
  - Release in the same cycle a timer expires: release wins, no pulse.
- Rules for simultaneous events and reset:
  - jump_pulse and start_pulse may assert in the same cycle.
  - Reset mid-hold returns to J_IDLE with no pulse.
  - After reset, an input already pressed produces its pulse only after a full STABLE_CYCLES window.
- Timers are 32-bit down-counters.

Decomposition:
- Package psx_pkg holds the shared constants:
  - Button bit indices: BTN_SELECT=15, BTN_START=12, BTN_UP=11, BTN_DOWN=9, BTN_CIRCLE=2, BTN_CROSS=1.
  - IDLE_BUTTONS=16'hFFFF, STICK_CENTER=8'h80.
  - Jump FSM state encodings.
  - The console poller shares this package.
- Sub-module psx_stability_filter (parameter STABLE_CYCLES; width 48) outputs the snapshot and a new-snapshot strobe. The decoder top holds the action logic and the jump FSM.

Test Plan (STABLE_CYCLES=16, REPEAT_DELAY=40, REPEAT_PERIOD=20, DEADZONE=8'h30):
- Reset, then drive the idle value for 100 cycles → all outputs 0, snap_valid never asserts.
- Torn-input test: button_state goes 16'hFFFF → 16'hFFFD (CROSS) with bit 0 toggling every 8 cycles for 64 cycles, then held → no jump_pulse during toggling. Exactly one jump_pulse 17 cycles after the last change; snap_valid 16 cycles after the last change.
- CROSS held 100 stable cycles → jump_pulse at first acceptance +1, then +40, +60, +80; jump_held=1 throughout. Release → jump_held falls and pulses stop.
- ly=8'h50 (edge, not up) → no jump. ly=8'h4F → jump. ly=8'hB0 → no duck. ly=8'hB1 → duck=1. ly=8'h4F with DOWN pressed → duck=0, jump_held=1.
- START pressed, stable → one start_pulse. START held 200 cycles → no further pulses. Release then re-press → second pulse.
- rst asserted for 1 cycle in J_REPEAT with CROSS held → outputs 0 the next cycle. Next jump_pulse exactly 17 cycles after rst deasserts.

Source files
------------

// File: rtl/psx_pkg.sv
// psx_pkg
// Shared constants for the PSX controller path (console poller and input
// decoder): button bit positions within the active-low button word, the idle
// controller value, and the jump state machine encoding.
// No ports; import with `import psx_pkg::*;`.
package psx_pkg;

  // Bit positions inside button_state (active-low on the wire).
  localparam int BTN_SELECT = 15;
  localparam int BTN_START  = 12;
  localparam int BTN_UP     = 11;
  localparam int BTN_DOWN   = 9;
  localparam int BTN_CIRCLE = 2;
  localparam int BTN_CROSS  = 1;

  localparam logic [15:0] IDLE_BUTTONS = 16'hFFFF;
  localparam logic [7:0]  STICK_CENTER = 8'h80;
  localparam logic [31:0] IDLE_STICK   = {4{STICK_CENTER}};

  // Snapshot layout is {button_state, stick_state}.
  localparam logic [47:0] IDLE_SNAPSHOT = {IDLE_BUTTONS, IDLE_STICK};

  typedef enum logic [1:0] {
    J_IDLE   = 2'd0,
    J_HOLD   = 2'd1,
    J_REPEAT = 2'd2
  } jump_state_e;

endpackage

// File: rtl/psx_stability_filter.sv
// psx_stability_filter
// Accepts a multi-bit input as a snapshot only after it has stayed unchanged
// for STABLE_CYCLES consecutive cycles, so values torn mid-update by the
// poller are never seen downstream.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   din      in   WIDTH  raw input, possibly torn
//   snap     out  WIDTH  last accepted snapshot (RESET_VALUE after reset)
//   snap_new out  1      one-cycle strobe, asserted together with a snapshot
//                        that differs from the one it replaced
module psx_stability_filter #(
  parameter int               STABLE_CYCLES = 1024,
  parameter int               WIDTH         = 48,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] snap,
  output logic             snap_new
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             new_q, new_d;

  always_comb begin
    sample_d = din;
    cnt_d    = cnt_q;
    snap_d   = snap_q;
    new_d    = 1'b0;
    if (din != sample_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      // The counter saturates, so this capture fires once per quiet period.
      if (cnt_q == CNT_MAX - 1'b1) begin
        snap_d = din;
        new_d  = (din != snap_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= RESET_VALUE;
      snap_q   <= RESET_VALUE;
      cnt_q    <= '0;
      new_q    <= 1'b0;
    end else begin
      sample_q <= sample_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      new_q    <= new_d;
    end
  end

  assign snap     = snap_q;
  assign snap_new = new_q;

endmodule

// File: rtl/psx_input_decoder.sv
// psx_input_decoder
// Turns raw PSX controller state into clean game actions for the T-Rex core:
// stability-filtered snapshot, jump (with auto-repeat), duck and start.
// Ports:
//   clk           in   system clock (shared with the console poller)
//   rst           in   synchronous reset, active-high
//   button_state  in   16  raw buttons, active-low
//   stick_state   in   32  {rx, ry, lx, ly}; ly 8'h00 = full up
//   snap_valid    out  1   pulse when a new, different snapshot is accepted
//   snap_buttons  out  16  accepted buttons, active-high
//   jump_pulse    out  1   one-cycle jump request (first press + auto-repeat)
//   jump_held     out  1   jump condition true in the current snapshot
//   duck          out  1   duck condition true and jump not true
//   start_pulse   out  1   one-cycle pulse on START press
module psx_input_decoder
  import psx_pkg::*;
#(
  parameter int          STABLE_CYCLES = 1024,
  parameter logic [7:0]  DEADZONE      = 8'h30,
  parameter int unsigned REPEAT_DELAY  = 600000,
  parameter int unsigned REPEAT_PERIOD = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] button_state,
  input  logic [31:0] stick_state,
  output logic        snap_valid,
  output logic [15:0] snap_buttons,
  output logic        jump_pulse,
  output logic        jump_held,
  output logic        duck,
  output logic        start_pulse
);

  logic [47:0] snap_w;
  logic        snap_new_w;

  psx_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WIDTH         (48),
    .RESET_VALUE   (IDLE_SNAPSHOT)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .din      ({button_state, stick_state}),
    .snap     (snap_w),
    .snap_new (snap_new_w)
  );

  assign snap_valid = snap_new_w;

  // Accepted buttons, inverted to active-high.
  logic [15:0] btn;
  for (genvar gi = 0; gi < 16; gi++) begin : g_btn
    assign btn[gi] = ~snap_w[32+gi];
  end
  assign snap_buttons = btn;

  // Only the left-stick Y axis drives actions; the other axes are carried
  // in the snapshot for change detection only.
  logic       stick_unused;
  assign stick_unused = ^snap_w[31:8];

  logic [7:0] ly;
  assign ly = snap_w[7:0];

  // Thresholds in 9 bits so a large deadzone cannot wrap around.
  logic [8:0] lo_thr, hi_thr;
  assign lo_thr = {1'b0, STICK_CENTER} - {1'b0, DEADZONE};
  assign hi_thr = {1'b0, STICK_CENTER} + {1'b0, DEADZONE};

  logic up, dn;
  assign up = btn[BTN_UP]   | btn[BTN_CROSS]  | ({1'b0, ly} < lo_thr);
  assign dn = btn[BTN_DOWN] | btn[BTN_CIRCLE] | ({1'b0, ly} > hi_thr);

  jump_state_e state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic        jump_pulse_q, jump_pulse_d;
  logic        jump_held_q, jump_held_d;
  logic        duck_q, duck_d;
  logic        start_prev_q, start_prev_d;
  logic        start_pulse_q, start_pulse_d;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    jump_pulse_d  = 1'b0;
    jump_held_d   = up;
    duck_d        = dn & ~up;
    start_prev_d  = btn[BTN_START];
    start_pulse_d = btn[BTN_START] & ~start_prev_q;

    // The timer is loaded with the full interval and a pulse is issued on
    // the cycle it would step to zero, so pulses land exactly REPEAT_DELAY /
    // REPEAT_PERIOD cycles apart. Release is checked first so it beats an
    // expiring timer.
    case (state_q)
      J_IDLE: begin
        if (up) begin
          jump_pulse_d = 1'b1;
          timer_d      = 32'(REPEAT_DELAY);
          state_d      = J_HOLD;
        end
      end
      J_HOLD: begin
        if (!up) begin
          state_d = J_IDLE;
        end else if (timer_q <= 32'd1) begin
          jump_pulse_d = 1'b1;
          timer_d      = 32'(REPEAT_PERIOD);
          state_d      = J_REPEAT;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      J_REPEAT: begin
        if (!up) begin
          state_d = J_IDLE;
        end else if (timer_q <= 32'd1) begin
          jump_pulse_d = 1'b1;
          timer_d      = 32'(REPEAT_PERIOD);
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      default: begin
        state_d = J_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= J_IDLE;
      timer_q       <= '0;
      jump_pulse_q  <= 1'b0;
      jump_held_q   <= 1'b0;
      duck_q        <= 1'b0;
      start_prev_q  <= 1'b0;
      start_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      jump_pulse_q  <= jump_pulse_d;
      jump_held_q   <= jump_held_d;
      duck_q        <= duck_d;
      start_prev_q  <= start_prev_d;
      start_pulse_q <= start_pulse_d;
    end
  end

  assign jump_pulse  = jump_pulse_q;
  assign jump_held   = jump_held_q;
  assign duck        = duck_q;
  assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_psx_input_decoder.sv
// Testbench for psx_input_decoder with short timing parameters.
// A reference model derived from the action rules runs alongside every
// cycle; directed sequences and a deadzone table check fixed timings.
module tb_psx_input_decoder;

  localparam int         SC = 16;
  localparam int         RD = 40;
  localparam int         RP = 20;
  localparam int         DZ = 'h30;
  localparam logic [47:0] IDLE = {16'hFFFF, 32'h80808080};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] button_state = 16'hFFFF;
  logic [31:0] stick_state  = 32'h80808080;
  logic        snap_valid;
  logic [15:0] snap_buttons;
  logic        jump_pulse, jump_held, duck, start_pulse;

  always #5 clk = ~clk;

  psx_input_decoder #(
    .STABLE_CYCLES (SC),
    .DEADZONE      (8'(DZ)),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button_state (button_state),
    .stick_state  (stick_state),
    .snap_valid   (snap_valid),
    .snap_buttons (snap_buttons),
    .jump_pulse   (jump_pulse),
    .jump_held    (jump_held),
    .duck         (duck),
    .start_pulse  (start_pulse)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int jp_q[$];
  int sv_q[$];
  int sp_q[$];

  // ---------------- reference model (action rules) ----------------
  function automatic bit m_up(logic [47:0] s);
    logic [15:0] b;
    int          y;
    b = ~s[47:32];
    y = int'(s[7:0]);
    return b[11] | b[1] | (y < 128 - DZ);
  endfunction

  function automatic bit m_dn(logic [47:0] s);
    logic [15:0] b;
    int          y;
    b = ~s[47:32];
    y = int'(s[7:0]);
    return b[9] | b[2] | (y > 128 + DZ);
  endfunction

  function automatic bit m_start(logic [47:0] s);
    logic [15:0] b;
    b = ~s[47:32];
    return b[12];
  endfunction

  logic [47:0] m_last, m_snap, m_snap_prev;
  int          m_run;
  bit          m_up_active;
  int          m_up_start;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    logic [47:0] raw;
    logic [20:0] exp_v, got_v;
    bit          e_sv, e_jp, e_jh, e_dk, e_sp, acc, u;
    int          d;
    raw = {button_state, stick_state};
    cyc++;
    if (rst) begin
      m_on = 1'b1;
      m_last = IDLE; m_snap = IDLE; m_snap_prev = IDLE;
      m_run = 1; m_up_active = 1'b0;
      exp_v = '0;
    end else begin
      u    = m_up(m_snap);
      e_jh = u;
      e_dk = m_dn(m_snap) & ~u;
      e_sp = m_start(m_snap) & ~m_start(m_snap_prev);
      e_jp = 1'b0;
      if (u) begin
        if (!m_up_active) begin
          m_up_active = 1'b1;
          m_up_start  = cyc;
        end
        d    = cyc - m_up_start;
        e_jp = (d == 0) || (d >= RD && ((d - RD) % RP) == 0);
      end else begin
        m_up_active = 1'b0;
      end
      if (raw == m_last) begin
        if (m_run < SC + 2) m_run++;
      end else begin
        m_run = 1;
      end
      m_last = raw;
      acc    = (m_run == SC + 1) && (raw == m_last);
      e_sv   = acc && (raw != m_snap);
      m_snap_prev = m_snap;
      if (acc) m_snap = raw;
      exp_v = {e_sv, ~m_snap[47:32], e_jp, e_jh, e_dk, e_sp};
    end
    #1;
    got_v = {snap_valid, snap_buttons, jump_pulse, jump_held, duck, start_pulse};
    if (m_on) begin
      n_vec++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs at cycle %0d: got %h expected %h", cyc, got_v, exp_v);
      end
    end
    if (jump_pulse === 1'b1)  jp_q.push_back(cyc);
    if (snap_valid === 1'b1)  sv_q.push_back(cyc);
    if (start_pulse === 1'b1) sp_q.push_back(cyc);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_from(input int q[$], input int lo);
    foreach (q[i]) if (q[i] >= lo) return q[i];
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic drive(input logic [15:0] b, input logic [31:0] s, output int t);
    @(negedge clk);
    button_state = b;
    stick_state  = s;
    t = cyc + 1;  // first edge that samples the new value
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int all_outs();
    return int'({snap_valid, snap_buttons, jump_pulse, jump_held, duck, start_pulse});
  endfunction

  function automatic void clear_q();
    jp_q.delete(); sv_q.delete(); sp_q.delete();
  endfunction

  typedef struct {
    logic [15:0] b;
    logic [31:0] s;
    bit          held;
    bit          dk;
  } dz_vec_t;

  dz_vec_t dz_tab[10];

  initial begin
    int t, t0, tl, tr, td, drops;
    logic [15:0] b;
    logic [15:0] rb;
    logic [31:0] rs;

    // Reset state
    wait_cyc(3);
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;

    // Idle for 100 cycles
    clear_q();
    wait_cyc(100);
    check("idle_snap_valid_count", sv_q.size(), 0);
    check("idle_outputs", all_outs(), 0);

    // Torn input: CROSS with bit 0 toggling every 8 cycles
    clear_q();
    b = 16'hFFFD;
    drive(b, 32'h80808080, t0);
    tl = t0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(7);
      b[0] = ~b[0];
      drive(b, 32'h80808080, tl);
    end
    wait_cyc(40);
    check("torn_no_early_jump", count_in(jp_q, t0, tl + 16), 0);
    check("torn_snap_valid_at", first_from(sv_q, t0) - tl, 16);
    check("torn_snap_valid_count", count_in(sv_q, t0, tl + 39), 1);
    check("torn_jump_at", first_from(jp_q, t0) - tl, 17);
    check("torn_jump_count", count_in(jp_q, t0, tl + 39), 1);
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);

    // CROSS held: first pulse then auto-repeat at +40, +60, +80
    clear_q();
    drops = 0;
    drive(16'hFFFD, 32'h80808080, t);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc >= t + 17 && jump_held !== 1'b1) drops++;
    end
    check("hold_pulse0", qget(jp_q, 0) - t, 17);
    check("hold_pulse1", qget(jp_q, 1) - qget(jp_q, 0), 40);
    check("hold_pulse2", qget(jp_q, 2) - qget(jp_q, 0), 60);
    check("hold_pulse3", qget(jp_q, 3) - qget(jp_q, 0), 80);
    check("hold_jump_held_drops", drops, 0);
    drive(16'hFFFF, 32'h80808080, tr);
    wait_cyc(40);
    check("release_jump_held", int'(jump_held), 0);
    check("release_no_pulse", count_in(jp_q, tr + 17, tr + 39), 0);

    // Deadzone and conflict table
    dz_tab[0] = '{16'hFFFF, 32'h80808050, 1'b0, 1'b0};
    dz_tab[1] = '{16'hFFFF, 32'h8080804F, 1'b1, 1'b0};
    dz_tab[2] = '{16'hFFFF, 32'h808080B0, 1'b0, 1'b0};
    dz_tab[3] = '{16'hFFFF, 32'h808080B1, 1'b0, 1'b1};
    dz_tab[4] = '{16'hFDFF, 32'h8080804F, 1'b1, 1'b0};
    dz_tab[5] = '{16'hFDFF, 32'h80808080, 1'b0, 1'b1};
    dz_tab[6] = '{16'hFFFB, 32'h80808080, 1'b0, 1'b1};
    dz_tab[7] = '{16'hFFF9, 32'h80808080, 1'b1, 1'b0};
    dz_tab[8] = '{16'hF7FF, 32'h808080FF, 1'b1, 1'b0};
    dz_tab[9] = '{16'hFFFF, 32'h00000080, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(dz_tab[i].b, dz_tab[i].s, t);
      wait_cyc(20);
      check($sformatf("dz_jump_held[%0d]", i), int'(jump_held), int'(dz_tab[i].held));
      check($sformatf("dz_duck[%0d]", i), int'(duck), int'(dz_tab[i].dk));
    end
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);

    // START: one pulse per press, none while held
    clear_q();
    drive(16'hEFFF, 32'h80808080, t);
    wait_cyc(200);
    check("start_at", first_from(sp_q, t) - t, 17);
    check("start_once", sp_q.size(), 1);
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);
    drive(16'hEFFF, 32'h80808080, t);
    wait_cyc(30);
    check("start_repress", sp_q.size(), 2);
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);

    // START and CROSS together: both pulses in the same cycle
    clear_q();
    drive(16'hEFFD, 32'h80808080, t);
    wait_cyc(25);
    check("combo_jump_at", first_from(jp_q, t) - t, 17);
    check("combo_start_at", first_from(sp_q, t) - t, 17);
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);

    // Reset while in auto-repeat
    clear_q();
    drive(16'hFFFD, 32'h80808080, t);
    wait_cyc(70);
    @(negedge clk);
    rst = 1'b1;
    tr  = cyc + 1;
    @(negedge clk);
    check("rst_mid_outputs", all_outs(), 0);
    rst = 1'b0;
    td  = cyc + 1;
    wait_cyc(30);
    check("rst_no_pulse", count_in(jp_q, tr, td + 16), 0);
    check("rst_next_jump_at", first_from(jp_q, tr) - td, 17);
    check("rst_snap_valid_at", first_from(sv_q, tr) - td, 16);
    drive(16'hFFFF, 32'h80808080, t);
    wait_cyc(30);

    // Randomized traffic checked cycle-by-cycle against the model
    for (int seg = 0; seg < 150; seg++) begin
      int hold;
      int sel;
      rb = 16'hFFFF;
      if ($urandom_range(0, 3) == 0) rb[1]  = 1'b0;
      if ($urandom_range(0, 3) == 0) rb[2]  = 1'b0;
      if ($urandom_range(0, 3) == 0) rb[9]  = 1'b0;
      if ($urandom_range(0, 3) == 0) rb[11] = 1'b0;
      if ($urandom_range(0, 3) == 0) rb[12] = 1'b0;
      if ($urandom_range(0, 7) == 0) rb[15] = 1'b0;
      sel = $urandom_range(0, 6);
      rs  = 32'h80808080;
      case (sel)
        0: rs[7:0] = 8'h50;
        1: rs[7:0] = 8'h4F;
        2: rs[7:0] = 8'hB0;
        3: rs[7:0] = 8'hB1;
        4: rs = $urandom;
        default: rs[7:0] = 8'h80;
      endcase
      hold = $urandom_range(1, 45);
      drive(rb, rs, t);
      for (int k = 1; k < hold; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 40) == 0) button_state[0] = ~button_state[0];
      end
      if ($urandom_range(0, 29) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        wait_cyc($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    wait_cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
